// File: rtl/rf_writeback_queue_if.sv
// rtl/rf_writeback_queue_if.sv - commit-side write request and register-file write port bundle
interface rf_writeback_queue_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  // Commit path side: issues requests, observes acceptance and the write port.
  modport master (
    output in_valid, in_addr, in_data,
    input  in_ready, wen, waddr, wdata
  );

  // Queue side: accepts requests and drives the register file write port.
  modport slave (
    input  in_valid, in_addr, in_data,
    output in_ready, wen, waddr, wdata
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// rtl/rf_writeback_queue.sv - in-order register write queue with two-port bypass lookup
module rf_writeback_queue #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  rf_writeback_queue_if.slave   bus,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_hit,
  output logic                  rs2_hit,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [CW-1:0]         count
);

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic                  push;
  logic                  pop;
  logic [PW-1:0]         idx;

  // Readiness depends only on registered occupancy; a same-cycle pop never frees a slot.
  assign bus.in_ready = (count < CW'(DEPTH));
  // x0 requests complete the handshake but are never stored.
  assign push = bus.in_valid && bus.in_ready && (bus.in_addr != '0);
  // The output stage drains one entry every cycle whenever anything is queued.
  assign pop  = (count != '0);

  // FIFO storage, pointers, occupancy and the registered write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      bus.wen   <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
    end else begin
      if (push) begin
        mem_addr[tail] <= bus.in_addr;
        mem_data[tail] <= bus.in_data;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        bus.wen   <= 1'b1;
        bus.waddr <= mem_addr[head];
        bus.wdata <= mem_data[head];
        head      <= head + PW'(1);
      end else begin
        bus.wen   <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Bypass: scan oldest (output stage) to youngest FIFO entry so the last match wins.
  always_comb begin
    rs1_hit  = 1'b0;
    rs1_data = '0;
    rs2_hit  = 1'b0;
    rs2_data = '0;
    idx      = '0;
    if (bus.wen) begin
      if ((rs1_addr != '0) && (bus.waddr == rs1_addr)) begin
        rs1_hit  = 1'b1;
        rs1_data = bus.wdata;
      end
      if ((rs2_addr != '0) && (bus.waddr == rs2_addr)) begin
        rs2_hit  = 1'b1;
        rs2_data = bus.wdata;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if ((rs1_addr != '0) && (mem_addr[idx] == rs1_addr)) begin
          rs1_hit  = 1'b1;
          rs1_data = mem_data[idx];
        end
        if ((rs2_addr != '0) && (mem_addr[idx] == rs2_addr)) begin
          rs2_hit  = 1'b1;
          rs2_data = mem_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb/tb_rf_writeback_queue.sv - directed self-checking bench for rf_writeback_queue
module tb_rf_writeback_queue;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic          rs1_hit, rs2_hit;
  logic [DW-1:0] rs1_data, rs2_data;
  logic [CW-1:0] count;

  rf_writeback_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rf_writeback_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .count    (count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic [AW+DW-1:0] sb [$];
  logic [AW+DW-1:0] exp_entry;
  logic             rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_wport();
    if (bus.wen === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", {bus.waddr, bus.wdata}, '0);
      end else begin
        exp_entry = sb.pop_front();
        check("sb_waddr", bus.waddr, exp_entry[AW+DW-1:DW]);
        check("sb_wdata", bus.wdata, exp_entry[DW-1:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd5;
    bus.in_data  = 32'h5555_5555;
    rs1_addr = 5'd5;
    rs2_addr = 5'd5;
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("rst_wen", bus.wen, 1'b0);
    check("rst_waddr", bus.waddr, 5'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_count", count, 3'd0);
    check("rst_ready", bus.in_ready, 1'b1);
    check("rst_hit1", rs1_hit, 1'b0);
    check("rst_hit2", rs2_hit, 1'b0);
    check("rst_data1", rs1_data, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_wen", bus.wen, 1'b0);

    // single write r5 = DEADBEEF accepted at edge k
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd5;
    bus.in_data  = 32'hDEAD_BEEF;
    tick();
    bus.in_valid = 1'b0;
    check("one_k_wen", bus.wen, 1'b0);
    check("one_k_count", count, 3'd1);
    check("one_k_hit", rs1_hit, 1'b1);
    check("one_k_data", rs1_data, 32'hDEAD_BEEF);
    tick();
    check("one_k1_wen", bus.wen, 1'b1);
    check("one_k1_waddr", bus.waddr, 5'd5);
    check("one_k1_wdata", bus.wdata, 32'hDEAD_BEEF);
    check("one_k1_count", count, 3'd0);
    check("one_k1_hit", rs1_hit, 1'b1);
    tick();
    check("one_k2_wen", bus.wen, 1'b0);
    check("one_k2_hit", rs1_hit, 1'b0);
    check("one_k2_waddr_hold", bus.waddr, 5'd5);

    // write to x0 is dropped
    rs1_addr = 5'd0;
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd0;
    bus.in_data  = 32'h1234;
    check("x0_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("x0_count", count, 3'd0);
    check("x0_hit", rs1_hit, 1'b0);
    tick();
    check("x0_wen", bus.wen, 1'b0);

    // back-to-back r3=1, r3=2, r7=9
    rs1_addr = 5'd3;
    rs2_addr = 5'd7;
    bus.in_valid = 1'b1;
    bus.in_addr = 5'd3; bus.in_data = 32'd1;
    tick();
    check("b2b_e1_wen", bus.wen, 1'b0);
    check("b2b_e1_rs1", rs1_data, 32'd1);
    check("b2b_e1_hit2", rs2_hit, 1'b0);
    bus.in_addr = 5'd3; bus.in_data = 32'd2;
    tick();
    check("b2b_e2_wen", bus.wen, 1'b1);
    check("b2b_e2_waddr", bus.waddr, 5'd3);
    check("b2b_e2_wdata", bus.wdata, 32'd1);
    check("b2b_e2_rs1", rs1_data, 32'd2);
    check("b2b_e2_hit2", rs2_hit, 1'b0);
    bus.in_addr = 5'd7; bus.in_data = 32'd9;
    tick();
    bus.in_valid = 1'b0;
    check("b2b_e3_wen", bus.wen, 1'b1);
    check("b2b_e3_waddr", bus.waddr, 5'd3);
    check("b2b_e3_wdata", bus.wdata, 32'd2);
    check("b2b_e3_rs1", rs1_data, 32'd2);
    check("b2b_e3_rs2", rs2_data, 32'd9);
    tick();
    check("b2b_e4_wen", bus.wen, 1'b1);
    check("b2b_e4_waddr", bus.waddr, 5'd7);
    check("b2b_e4_hit1", rs1_hit, 1'b0);
    check("b2b_e4_data1", rs1_data, 32'd0);
    check("b2b_e4_rs2", rs2_data, 32'd9);
    tick();
    check("b2b_e5_wen", bus.wen, 1'b0);
    check("b2b_e5_hit2", rs2_hit, 1'b0);

    // sustained stream: DEPTH+4 distinct addresses, then wrap over 3*DEPTH more
    for (int i = 0; i < (D + 4) + 3 * D; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = AW'((i % 31) + 1);
      bus.in_data  = 32'h100 + 32'(i);
      rdy = bus.in_ready;
      check("stream_ready", rdy, 1'b1);
      tick();
      if (rdy) sb.push_back({bus.in_addr, bus.in_data});
      check("stream_count", count, 3'd1);
      if (i > 0) check("stream_wen", bus.wen, 1'b1);
      check_wport();
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 6 && sb.size() != 0; c++) begin
      tick();
      check_wport();
    end
    check("stream_drained", 64'(sb.size()), 64'd0);
    tick();
    check("stream_idle_wen", bus.wen, 1'b0);
    check("stream_idle_count", count, 3'd0);

    // reset while a write is in the output stage and another is queued
    rs1_addr = 5'd11;
    rs2_addr = 5'd10;
    bus.in_valid = 1'b1;
    bus.in_addr = 5'd10; bus.in_data = 32'hA;
    tick();
    bus.in_addr = 5'd11; bus.in_data = 32'hB;
    tick();
    check("prerst_wen", bus.wen, 1'b1);
    check("prerst_hit1", rs1_hit, 1'b1);
    bus.in_addr = 5'd12; bus.in_data = 32'hC;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check("mrst_wen", bus.wen, 1'b0);
    check("mrst_count", count, 3'd0);
    check("mrst_ready", bus.in_ready, 1'b1);
    check("mrst_hit1", rs1_hit, 1'b0);
    check("mrst_hit2", rs2_hit, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("mrst_no_write", bus.wen, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
